// File: rtl/ssp_rx_fifo_pkg.sv
// Shared constants and small helpers for the SSP receive FIFO.
package ssp_rx_fifo_pkg;

    // Default geometry of the receive FIFO.
    localparam int SSP_DATA_W     = 8;
    localparam int SSP_FIFO_DEPTH = 4;
    localparam int SSP_FIFO_AW    = 2;

    // Occupancy update selected each cycle from the commit/pop pair.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // Commit and pop together leave the occupancy unchanged.
    function automatic cnt_op_e f_cnt_op(input logic commit, input logic pop);
        cnt_op_e op;
        op = CNT_HOLD;
        if (commit && !pop) begin
            op = CNT_INC;
        end else if (pop && !commit) begin
            op = CNT_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/ssp_rx_fifo_edge_det.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level is high.
module ssp_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic r_level_q;

    // Remember the previous level so a held level produces only one pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= level;
        end
    end

    assign rise = level && !r_level_q;

endmodule

// File: rtl/ssp_rx_fifo.sv
// SSP receive FIFO: captures bytes from the serial receiver on a write strobe
// edge, holds one byte pending while full, and pops the oldest byte onto
// PRDATA once per APB read.
module ssp_rx_fifo
    import ssp_rx_fifo_pkg::*;
#(
    parameter int WIDTH = SSP_DATA_W,
    parameter int DEPTH = SSP_FIFO_DEPTH,
    parameter int AW    = SSP_FIFO_AW
) (
    input  logic             PCLK,
    input  logic             CLEAR,
    input  logic             PSEL,
    input  logic             PWRITE,
    input  logic [WIDTH-1:0] RxData,
    input  logic             write_fifo,
    output logic [WIDTH-1:0] PRDATA,
    output logic             rx_fifo_full,
    output logic             rx_fifo_empty,
    output logic             SSPRXINTR,
    output logic             rx_overrun,
    output logic [AW:0]      rx_count
);

    localparam logic [AW:0] L_DEPTH = DEPTH[AW:0];
    localparam logic [AW:0] L_ZERO  = '0;

    // Storage and control state.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_pend;
    logic [WIDTH-1:0] r_pend_data;
    logic [WIDTH-1:0] r_prdata;
    logic             r_overrun;

    // Decoded per-cycle events.
    logic             w_rd_level;
    logic             w_wr_edge;
    logic             w_rd_edge;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_commit;
    logic [DEPTH-1:0] w_wsel;
    cnt_op_e          w_cnt_op;

    assign w_rd_level = PSEL && !PWRITE;

    // One write per rising edge of the receiver strobe.
    ssp_edge_det u_wr_edge (
        .clk   (PCLK),
        .rst   (CLEAR),
        .level (write_fifo),
        .rise  (w_wr_edge)
    );

    // One pop per APB read, however long PSEL stays high.
    ssp_edge_det u_rd_edge (
        .clk   (PCLK),
        .rst   (CLEAR),
        .level (w_rd_level),
        .rise  (w_rd_edge)
    );

    // Flags come straight from the registered occupancy.
    assign w_full  = (r_count == L_DEPTH);
    assign w_empty = (r_count == L_ZERO);

    // A read against an empty FIFO is ignored, even if a commit lands the
    // same cycle; a pop frees a slot so a pending byte may enter while full.
    assign w_pop    = w_rd_edge && !w_empty;
    assign w_commit = r_pend && (!w_full || w_pop);
    assign w_cnt_op = f_cnt_op(w_commit, w_pop);

    // Per-entry write enables for the flop array.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
            assign w_wsel[gi] = w_commit && (r_wptr == AW'(gi));

            // Each entry loads the pending byte when it is the write target.
            always_ff @(posedge PCLK) begin
                if (w_wsel[gi]) begin
                    r_mem[gi] <= r_pend_data;
                end
            end
        end
    endgenerate

    // Pending byte holder between the strobe edge and the commit.
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_pend      <= 1'b0;
            r_pend_data <= '0;
        end else if (w_wr_edge) begin
            r_pend      <= 1'b1;
            r_pend_data <= RxData;
        end else if (w_commit) begin
            r_pend      <= 1'b0;
        end
    end

    // Sticky overrun: a new byte arrived while the pending one could not
    // move into the array, so the older pending byte is lost.
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_overrun <= 1'b0;
        end else if (w_wr_edge && r_pend && !w_commit) begin
            r_overrun <= 1'b1;
        end
    end

    // Write pointer advances on every commit and wraps modulo DEPTH.
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_wptr <= '0;
        end else if (w_commit) begin
            r_wptr <= r_wptr + 1'b1;
        end
    end

    // Read pointer and registered read data advance on every pop.
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_rptr   <= '0;
            r_prdata <= '0;
        end else if (w_pop) begin
            r_rptr   <= r_rptr + 1'b1;
            r_prdata <= r_mem[r_rptr];
        end
    end

    // Occupancy tracks commits and pops; both together cancel out.
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_count <= '0;
        end else begin
            case (w_cnt_op)
                CNT_INC: r_count <= r_count + 1'b1;
                CNT_DEC: r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign PRDATA        = r_prdata;
    assign rx_fifo_full  = w_full;
    assign rx_fifo_empty = w_empty;
    assign SSPRXINTR     = w_full;
    assign rx_overrun    = r_overrun;
    assign rx_count      = r_count;

endmodule
